// File: rtl/seg_disp_arbiter_pkg.sv
// Shared display types and constants: arbiter state encoding, display
// saturation limit and default ownership hold time.
package seg_disp_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   localparam logic [19:0] DISP_MAX     = 20'd999_999;
   localparam logic [23:0] HOLD_MAX_DEF = 24'd9_999_999;

   // Six decimal digits is all the display can show; clamp anything larger.
   function automatic logic [19:0] sat_disp(input logic [19:0] v);
      return (v > DISP_MAX) ? DISP_MAX : v;
   endfunction

endpackage

// File: rtl/seg_disp_arbiter.sv
// Two-requester round-robin arbiter for the seven-segment display; sits
// between the data sources and seg_595_dynamic.
module seg_disp_arbiter
   import seg_disp_arbiter_pkg::*;
#(
   parameter logic [23:0] HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [19:0] data_a,
   input  logic [19:0] data_b,
   input  logic [5:0]  dp_a,
   input  logic [5:0]  dp_b,
   input  logic        sign_a,
   input  logic        sign_b,
   input  logic        seg_en_a,
   input  logic        seg_en_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [19:0] data,
   output logic [5:0]  dp,
   output logic        sign,
   output logic        seg_en
);

   arb_state_e  state_q, state_d;
   logic [23:0] hold_cnt_q, hold_cnt_d;
   logic        last_owner_q, last_owner_d;   // 0 = A, 1 = B

   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic [19:0] data_q, data_d;
   logic [5:0]  dp_q, dp_d;
   logic        sign_q, sign_d;
   logic        seg_en_q, seg_en_d;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_owner_q <= last_owner_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if (req_a && (!req_b || last_owner_q))
               state_d = OWN_A;
            else if (req_b)
               state_d = OWN_B;
         end
         OWN_A: begin
            if (hold_cnt_q < HOLD_MAX)
               hold_cnt_d = hold_cnt_q + 24'd1;
            else if (req_b)
               state_d = OWN_B;
            else if (!req_a)
               state_d = IDLE;
         end
         OWN_B: begin
            if (hold_cnt_q < HOLD_MAX)
               hold_cnt_d = hold_cnt_q + 24'd1;
            else if (req_a)
               state_d = OWN_A;
            else if (!req_b)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Any change of owner restarts the hold window.
      if (state_d != state_q) begin
         hold_cnt_d = '0;
         if (state_d == OWN_A) last_owner_d = 1'b0;
         if (state_d == OWN_B) last_owner_d = 1'b1;
      end
   end

   // Outputs follow the next owner so they line up with the registered grant.
   always_comb begin
      gnt_a_d  = 1'b0;
      gnt_b_d  = 1'b0;
      data_d   = '0;
      dp_d     = '0;
      sign_d   = 1'b0;
      seg_en_d = 1'b0;
      case (state_d)
         OWN_A: begin
            gnt_a_d  = 1'b1;
            data_d   = sat_disp(data_a);
            dp_d     = dp_a;
            sign_d   = sign_a;
            seg_en_d = seg_en_a;
         end
         OWN_B: begin
            gnt_b_d  = 1'b1;
            data_d   = sat_disp(data_b);
            dp_d     = dp_b;
            sign_d   = sign_b;
            seg_en_d = seg_en_b;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         data_q   <= '0;
         dp_q     <= '0;
         sign_q   <= 1'b0;
         seg_en_q <= 1'b0;
      end else begin
         gnt_a_q  <= gnt_a_d;
         gnt_b_q  <= gnt_b_d;
         data_q   <= data_d;
         dp_q     <= dp_d;
         sign_q   <= sign_d;
         seg_en_q <= seg_en_d;
      end
   end

   assign gnt_a  = gnt_a_q;
   assign gnt_b  = gnt_b_q;
   assign data   = data_q;
   assign dp     = dp_q;
   assign sign   = sign_q;
   assign seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Self-checking bench for seg_disp_arbiter: directed scenarios followed by
// random traffic, checked against an ownership-level reference model.
module tb_seg_disp_arbiter;

   localparam int HOLD = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        req_a, req_b;
   logic [19:0] data_a, data_b;
   logic [5:0]  dp_a, dp_b;
   logic        sign_a, sign_b;
   logic        seg_en_a, seg_en_b;
   logic        gnt_a, gnt_b;
   logic [19:0] data;
   logic [5:0]  dp;
   logic        sign;
   logic        seg_en;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: owner 0 = none, 1 = A, 2 = B; held = cycles owned so far.
   int m_owner;
   int m_held;
   int m_last;

   seg_disp_arbiter #(.HOLD_MAX(24'(HOLD))) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .req_a    (req_a),
      .req_b    (req_b),
      .data_a   (data_a),
      .data_b   (data_b),
      .dp_a     (dp_a),
      .dp_b     (dp_b),
      .sign_a   (sign_a),
      .sign_b   (sign_b),
      .seg_en_a (seg_en_a),
      .seg_en_b (seg_en_b),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .data     (data),
      .dp       (dp),
      .sign     (sign),
      .seg_en   (seg_en)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_held  = 0;
      m_last  = 2;
   endtask

   task automatic grant(input int who);
      m_owner = who;
      m_held  = 1;
      m_last  = who;
   endtask

   task automatic model_step();
      logic req_own, req_oth;
      if (m_owner == 0) begin
         if (req_a && req_b) grant(m_last == 2 ? 1 : 2);
         else if (req_a)     grant(1);
         else if (req_b)     grant(2);
      end else if (m_held < HOLD + 1) begin
         m_held++;
      end else begin
         req_own = (m_owner == 1) ? req_a : req_b;
         req_oth = (m_owner == 1) ? req_b : req_a;
         if (req_oth)       grant(3 - m_owner);
         else if (!req_own) m_owner = 0;
      end
   endtask

   task automatic chk_all(input string tag);
      int unsigned exp_data;
      logic [5:0]  exp_dp;
      logic        exp_sign, exp_en;
      exp_data = 0; exp_dp = '0; exp_sign = 1'b0; exp_en = 1'b0;
      if (m_owner == 1) begin
         exp_data = (int'(data_a) > 999999) ? 999999 : int'(data_a);
         exp_dp = dp_a; exp_sign = sign_a; exp_en = seg_en_a;
      end else if (m_owner == 2) begin
         exp_data = (int'(data_b) > 999999) ? 999999 : int'(data_b);
         exp_dp = dp_b; exp_sign = sign_b; exp_en = seg_en_b;
      end
      chk({tag, ".gnt_a"},  32'(gnt_a),  32'(m_owner == 1));
      chk({tag, ".gnt_b"},  32'(gnt_b),  32'(m_owner == 2));
      chk({tag, ".data"},   32'(data),   exp_data);
      chk({tag, ".dp"},     32'(dp),     32'(exp_dp));
      chk({tag, ".sign"},   32'(sign),   32'(exp_sign));
      chk({tag, ".seg_en"}, 32'(seg_en), 32'(exp_en));
   endtask

   // Inputs are stable across the edge; model sees the same sampled values.
   task automatic tick(input string tag);
      @(posedge sys_clk);
      if (!sys_rst) model_step();
      #1;
      chk_all(tag);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      #1;
      model_reset();
      chk_all("reset_async");
      @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b0;
      req_a = 0; req_b = 0;
      data_a = '0; data_b = '0; dp_a = '0; dp_b = '0;
      sign_a = 0; sign_b = 0; seg_en_a = 0; seg_en_b = 0;
      model_reset();
      #2;
      do_reset();
      tick("idle");

      // Single requester from IDLE
      data_a = 20'd123456; dp_a = 6'b000100; seg_en_a = 1; sign_a = 1; req_a = 1;
      tick("grant_a");
      chk("grant_a.data_explicit", 32'(data), 32'd123456);
      chk("grant_a.dp_explicit",   32'(dp),   32'b000100);
      req_a = 0;
      for (int i = 0; i < 6; i++) tick("release_a");
      chk("release_a.idle_data", 32'(data), 32'd0);

      // Simultaneous requests right after reset: A first, then B, no overlap
      do_reset();
      req_a = 1; req_b = 1; data_b = 20'd42; seg_en_b = 1;
      for (int i = 0; i < 5; i++) tick("tie_a");
      chk("tie_a.still_a", 32'(gnt_a), 32'd1);
      tick("tie_switch");
      chk("tie_switch.gnt_b", 32'(gnt_b), 32'd1);
      chk("tie_switch.gnt_a", 32'(gnt_a), 32'd0);
      for (int i = 0; i < 6; i++) tick("tie_back");

      // B owns, A requests on B's first owned cycle
      do_reset();
      req_a = 0; req_b = 1;
      tick("b_own");
      req_a = 1;
      for (int i = 0; i < 4; i++) tick("b_hold");
      chk("b_hold.no_a", 32'(gnt_a), 32'd0);
      tick("a_after_b");
      chk("a_after_b.gnt_a", 32'(gnt_a), 32'd1);

      // Saturation while A owns
      req_b = 0;
      data_a = 20'hFFFFF;
      tick("sat_hi");
      chk("sat_hi.explicit", 32'(data), 32'd999999);
      data_a = 20'd999999;
      tick("sat_edge");
      data_a = 20'd1000000;
      tick("sat_over");

      // A drops its request early; ownership holds until expiry then IDLE
      do_reset();
      req_a = 1; req_b = 0; data_a = 20'd777;
      tick("drop_own");
      tick("drop_c2");
      req_a = 0;
      for (int i = 0; i < 4; i++) tick("drop_hold");
      chk("drop_idle.seg_en", 32'(seg_en), 32'd0);
      chk("drop_idle.gnt_a",  32'(gnt_a),  32'd0);

      // Reset pulsed mid-OWN_B
      req_b = 1; data_b = 20'd5555;
      tick("rst_b1");
      tick("rst_b2");
      sys_rst = 1'b1;
      #1;
      model_reset();
      chk_all("rst_mid");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      req_a = 1; req_b = 1;
      tick("rst_after");
      chk("rst_after.gnt_a", 32'(gnt_a), 32'd1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         req_a    = ($urandom_range(0, 3) != 0);
         req_b    = ($urandom_range(0, 3) != 0);
         data_a   = 20'($urandom_range(0, 20'hFFFFF));
         data_b   = 20'($urandom_range(0, 20'hFFFFF));
         dp_a     = 6'($urandom);
         dp_b     = 6'($urandom);
         sign_a   = 1'($urandom);
         sign_b   = 1'($urandom);
         seg_en_a = 1'($urandom);
         seg_en_b = 1'($urandom);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
